// File: rtl/npu_pkg.sv
// Shared definitions for the NPU line loaders: FSM encoding and default geometry.
package npu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int NPU_BIT_DEPTH  = 8;
  localparam int NPU_IMG_WIDTH  = 28;
  localparam int NPU_IMG_HEIGHT = 28;
  localparam int NPU_NUM_ROWS   = 3;
  localparam int NPU_ADDR_W     = 10;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO with valid/ready on both sides; head entry drives the output.
module skid_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic             push;
  logic             pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = head_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      count  <= 2'd0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            head_q <= in_data;
            count  <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_q <= in_data;
          end else if (push) begin
            tail_q <= in_data;
            count  <= 2'd2;
          end else if (pop) begin
            count  <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head_q <= tail_q;
            count  <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/line_window_loader.sv
// Streams one image-row window (NUM_ROWS lanes) from memory as IMG_WIDTH column
// beats, zero-padding lanes that fall below the bottom image border.
module line_window_loader
  import npu_pkg::*;
#(
  parameter int BIT_DEPTH  = NPU_BIT_DEPTH,
  parameter int IMG_WIDTH  = NPU_IMG_WIDTH,
  parameter int IMG_HEIGHT = NPU_IMG_HEIGHT,
  parameter int NUM_ROWS   = NPU_NUM_ROWS,
  parameter int ADDR_W     = NPU_ADDR_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             row_num,
  output logic                          mem_rd_en,
  output logic [NUM_ROWS*ADDR_W-1:0]    mem_addr,
  input  logic [NUM_ROWS*BIT_DEPTH-1:0] mem_rdata,
  output logic [NUM_ROWS*BIT_DEPTH-1:0] dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic                          busy,
  output logic                          done
);

  localparam int DW = NUM_ROWS * BIT_DEPTH;

  state_t              state;
  logic [ADDR_W-1:0]   col_q;
  logic [ADDR_W-1:0]   base_q [NUM_ROWS];
  logic [ADDR_W-1:0]   base_d [NUM_ROWS];
  logic [ADDR_W:0]     row_ext [NUM_ROWS];
  logic [NUM_ROWS-1:0] pad_q;
  logic [NUM_ROWS-1:0] pad_d;
  logic                rd_vld_p1;
  logic [DW-1:0]       rdata_p1;
  logic [1:0]          occ;
  logic                fifo_in_ready;
  logic                pop;
  logic [2:0]          outstanding;
  logic                drain_empty;

  // Row bases and padding mask are derived from row_num and latched on start.
  always_comb begin
    for (int k = 0; k < NUM_ROWS; k++) begin
      row_ext[k] = {1'b0, row_num} + (ADDR_W+1)'(k);
      pad_d[k]   = (row_ext[k] >= (ADDR_W+1)'(IMG_HEIGHT));
      base_d[k]  = row_ext[k][ADDR_W-1:0] * ADDR_W'(IMG_WIDTH);
    end
  end

  // A beat popped this cycle frees its slot, which keeps one read per cycle.
  assign pop         = dout_valid && dout_ready;
  assign outstanding = {1'b0, occ} - {2'b00, pop} + {2'b00, rd_vld_p1};
  assign mem_rd_en   = (state == ST_FETCH) && (outstanding < 3'd2) && fifo_in_ready;
  assign drain_empty = (occ == 2'd0) || ((occ == 2'd1) && pop);

  always_comb begin
    mem_addr = '0;
    for (int k = 0; k < NUM_ROWS; k++) begin
      if (mem_rd_en && !pad_q[k]) begin
        mem_addr[k*ADDR_W +: ADDR_W] = base_q[k] + col_q;
      end
    end
  end

  // Stage p1: memory data returns one cycle after the read strobe.
  always_comb begin
    rdata_p1 = mem_rdata;
    for (int k = 0; k < NUM_ROWS; k++) begin
      if (pad_q[k]) begin
        rdata_p1[k*BIT_DEPTH +: BIT_DEPTH] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      col_q     <= '0;
      rd_vld_p1 <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pad_q     <= '0;
      for (int k = 0; k < NUM_ROWS; k++) base_q[k] <= '0;
    end else begin
      rd_vld_p1 <= mem_rd_en;
      done      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_FETCH;
            busy   <= 1'b1;
            col_q  <= '0;
            pad_q  <= pad_d;
            base_q <= base_d;
          end
        end
        ST_FETCH: begin
          if (mem_rd_en) begin
            col_q <= col_q + 1'b1;
            if (col_q == ADDR_W'(IMG_WIDTH - 1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_empty && !rd_vld_p1) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  skid_fifo2 #(
    .WIDTH(DW)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_data  (rdata_p1),
    .in_valid (rd_vld_p1),
    .in_ready (fifo_in_ready),
    .out_data (dout),
    .out_valid(dout_valid),
    .out_ready(dout_ready),
    .count    (occ)
  );

endmodule

// File: doc/line_window_loader.md
LINE_WINDOW_LOADER -- requirements
Module: line_window_loader

Interface
REQ-001 Parameter BIT_DEPTH, default 8: pixel width in bits.
REQ-002 Parameter IMG_WIDTH, default 28: pixels per image row, i.e. beats per window load.
REQ-003 Parameter IMG_HEIGHT, default 28: rows per image.
REQ-004 Parameter NUM_ROWS, default 3: parallel row lanes (kernel height), range 1..8.
REQ-005 Parameter ADDR_W, default 10: memory address width, at least clog2(IMG_WIDTH*IMG_HEIGHT).
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 start  input  1  load request, sampled in IDLE only.
REQ-009 row_num  input  ADDR_W  first image row of the window, latched on accepted start.
REQ-010 mem_rd_en  output  1  read strobe, common to all lanes.
REQ-011 mem_addr  output  NUM_ROWS*ADDR_W  per-lane pixel address; lane k at bits [k*ADDR_W +: ADDR_W].
REQ-012 mem_rdata  input  NUM_ROWS*BIT_DEPTH  per-lane read data, valid exactly 1 cycle after mem_rd_en.
REQ-013 dout  output  NUM_ROWS*BIT_DEPTH  column beat; lane k at bits [k*BIT_DEPTH +: BIT_DEPTH].
REQ-014 dout_valid  output  1  dout holds a beat.
REQ-015 dout_ready  input  1  consumer accepts beat when dout_valid && dout_ready.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse after final beat is accepted.

Function
REQ-018 FSM states IDLE, FETCH, DRAIN, DONE; IDLE->FETCH on start; FETCH->DRAIN after read for column IMG_WIDTH-1 issues; DRAIN->DONE when skid buffer empty and no read in flight; DONE->IDLE unconditionally.
REQ-019 start while busy is ignored; no queuing.
REQ-020 Lane k address = (row_num+k)*IMG_WIDTH + col, col = 0..IMG_WIDTH-1, computed at ADDR_W bits with no wrap.
REQ-021 Lane with row_num+k >= IMG_HEIGHT is padding: address driven 0, dout lane forced to 0 (zero-pad bottom border).
REQ-022 mem_rd_en asserts in FETCH only when (skid occupancy + reads in flight) < 2; col increments on each issued read.
REQ-023 Returned data enters a 2-entry skid buffer; dout/dout_valid driven from its head; no beat dropped or duplicated under any dout_ready pattern.
REQ-024 Exactly IMG_WIDTH beats per load, columns in ascending order.
REQ-025 With dout_ready held high, first dout_valid 2 cycles after start is sampled; one beat per cycle thereafter; done 1 cycle after last beat.
REQ-026 dout holds stable while dout_valid && !dout_ready.
REQ-027 start on the cycle done is high is ignored (state is DONE, not IDLE).

Reset
REQ-028 On rst low: state IDLE, col 0, skid buffer empty, in-flight flag 0; mem_rd_en, dout_valid, busy, done 0; dout and mem_addr 0.
REQ-029 Reset mid-load aborts immediately; data returned after reset release from a pre-reset read is discarded.

Structure
REQ-030 State encoding and default parameter values live in shared package npu_pkg.
REQ-031 Skid buffer is sub-module skid_fifo2 (2 entries, parametric width, valid/ready both sides); address/FSM logic stays in line_window_loader.

Verification
REQ-032 Defaults, memory model rdata = addr[7:0] per lane, row_num=0, ready high: 28 beats, beat 5 = {lane2 61, lane1 33, lane0 5}, done 1 cycle after beat 27.
REQ-033 row_num=26: lanes 0,1 read rows 26,27 (beat 0 lane0 = 728&0xFF = 216); lane 2 dout 0 and address 0 for all 28 beats.
REQ-034 dout_ready toggled by random 50% pattern: all 28 beats arrive once, in order, dout stable while stalled, mem_rd_en never leaves >2 outstanding.
REQ-035 start pulsed at cycles 3 and 10 of a running load: only one load, 28 beats, single done pulse.
REQ-036 rst low at beat 12: all outputs 0 next cycle; new start after release gives full 28-beat load from column 0.
REQ-037 NUM_ROWS=5, IMG_WIDTH=16, IMG_HEIGHT=16, row_num=2: lane 4 beat 3 address = 6*16+3 = 99; 16 beats then done.
